// File: rtl/pwm_multi.sv
// Multi-channel PWM with a shared prescaled period counter, edge/center-aligned
// counting, double-buffered per-channel duties and a period-start strobe.
module pwm_multi #(
    parameter int unsigned NCH     = 4,
    parameter int unsigned XLEN    = 8,
    parameter int unsigned PRESC_W = 8,
    localparam int unsigned CHW    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               mode,
    input  logic [PRESC_W-1:0] prescale,
    input  logic [XLEN-1:0]    period,
    input  logic               wr_en,
    input  logic [CHW-1:0]     wr_ch,
    input  logic [XLEN-1:0]    wr_duty,
    output logic [NCH-1:0]     out,
    output logic               period_start
);

    logic [PRESC_W-1:0] presc_cnt;
    logic [XLEN-1:0]    cnt;
    logic               dir_down;
    logic [XLEN-1:0]    period_act;
    logic               mode_act;
    logic [XLEN-1:0]    shadow   [NCH];
    logic [XLEN-1:0]    duty_act [NCH];

    logic [XLEN-1:0]    cnt_nxt;
    logic               dir_nxt;
    logic               tick;
    logic               boundary;

    // Next counter value/direction for the coming tick; boundary = next cnt is 0
    always_comb begin
        tick    = (presc_cnt == prescale);
        cnt_nxt = cnt;
        dir_nxt = dir_down;
        if (period_act == '0) begin
            cnt_nxt = '0;
            dir_nxt = 1'b0;
        end else if (!mode_act) begin
            cnt_nxt = (cnt >= period_act) ? '0 : cnt + XLEN'(1);
            dir_nxt = 1'b0;
        end else if (!dir_down) begin
            cnt_nxt = cnt + XLEN'(1);
            dir_nxt = (cnt_nxt >= period_act);
        end else begin
            cnt_nxt = cnt - XLEN'(1);
            dir_nxt = (cnt_nxt != '0);
        end
        boundary = tick && (cnt_nxt == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_cnt    <= '0;
            cnt          <= '0;
            dir_down     <= 1'b0;
            period_act   <= '0;
            mode_act     <= 1'b0;
            out          <= '0;
            period_start <= 1'b0;
            for (int unsigned i = 0; i < NCH; i++) begin
                shadow[i]   <= '0;
                duty_act[i] <= '0;
            end
        end else begin
            // Compare uses the pre-edge cnt, so out lags cnt by one clock
            for (int unsigned i = 0; i < NCH; i++) begin
                out[i] <= en && (cnt < duty_act[i]);
                if (wr_en && (wr_ch == CHW'(i)))
                    shadow[i] <= wr_duty;
            end
            period_start <= 1'b0;

            if (!en) begin
                // Disabled: hold the counter at its start point, keep active copies current
                presc_cnt  <= '0;
                cnt        <= '0;
                dir_down   <= 1'b0;
                period_act <= period;
                mode_act   <= mode;
                for (int unsigned i = 0; i < NCH; i++)
                    duty_act[i] <= shadow[i];
            end else if (tick) begin
                presc_cnt <= '0;
                cnt       <= cnt_nxt;
                dir_down  <= dir_nxt;
                if (boundary) begin
                    period_start <= 1'b1;
                    period_act   <= period;
                    mode_act     <= mode;
                    for (int unsigned i = 0; i < NCH; i++)
                        duty_act[i] <= shadow[i];
                end
            end else begin
                presc_cnt <= presc_cnt + PRESC_W'(1);
            end
        end
    end

endmodule

// File: doc/pwm_multi.md
# pwm_multi

Multi-channel PWM generator sharing one period counter across `NCH` outputs. It is the parametrised successor to the single-channel PWM. It adds:
- a clock prescaler;
- edge-aligned and center-aligned counting modes;
- per-channel double-buffered (shadow) duty registers, so duty updates are glitch-free and happen only at period boundaries;
- a period-start strobe for software/DMA synchronisation.

It sits between the register interface and the pad drivers for motor/LED control.

## Interface
- `NCH`, 4, number of PWM channels (≥1)
- `XLEN`, 8, counter/duty/period width
- `PRESC_W`, 8, prescaler width
- `CHW`, max(1,$clog2(NCH)), channel-select width (derived)

- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `en`  in  1  global enable
- `mode`  in  1  0 = edge-aligned, 1 = center-aligned
- `prescale`  in  PRESC_W  tick every prescale+1 clocks
- `period`  in  XLEN  period limit P
- `wr_en`  in  1  duty write strobe
- `wr_ch`  in  CHW  channel to write
- `wr_duty`  in  XLEN  duty value
- `out`  out  NCH  PWM outputs, registered
- `period_start`  out  1  one-cycle pulse when the counter restarts at 0

## Operation
- **Reset** (rst=1 at an edge) clears:
  - prescaler count, cnt, and all shadow and active duties to 0;
  - dir to up, and period_act/mode_act to 0;
  - out to all 0 and period_start to 0.
- **Prescaler:** presc_cnt increments each clock while en=1.
  - When presc_cnt == prescale, a tick occurs and presc_cnt returns to 0.
  - prescale=0 gives a tick on every clock.
- **Edge mode** (mode_act=0): on each tick, cnt goes 0,1,…,P_act,0,… giving P_act+1 ticks per period.
- **Center mode** (mode_act=1): cnt goes 0,1,…,P_act,P_act−1,…,1,0,… giving 2·P_act ticks per period.
  - dir flips to down after cnt reaches P_act.
  - dir flips to up when cnt returns to 0.
- **P_act = 0:** cnt stays 0 in either mode, and every tick is a boundary.
- **Boundary:** any tick whose next cnt value is 0. At a boundary:
  - every active duty takes its shadow value;
  - period_act takes `period` and mode_act takes `mode`;
  - period_start is 1 in the following cycle, aligned with cnt = 0.
- **Duty writes:** when wr_en=1, shadow[wr_ch] takes wr_duty.
  - wr_ch ≥ NCH: the write is ignored.
  - A write on the same edge as a boundary is not transferred at that boundary; the boundary uses the old shadow value, and the new value is transferred at the next boundary.
  - Multiple writes to one channel within a period: the last one wins.
- **Output:** out[i] is updated to en && (cnt < duty_act[i]) on every edge.
  - duty 0 gives constant 0.
  - duty > P_act gives constant 1 (100%).
- **en = 0:**
  - presc_cnt, cnt and dir are held at 0/up, and out is 0 after one clock.
  - Active duties, period_act and mode_act continuously track the shadow/inputs.
  - period_start stays 0, and shadow writes are still accepted.
  - On en rising, counting starts from cnt = 0 using the latest values. No period_start pulse is issued for this start.

## Timing
- out lags the cnt value by exactly one clock (registered compare).
- period_start is a single-clock pulse regardless of prescale.
- A duty write becomes visible on out no earlier than 1 clock after the next boundary.
- Changes to `period` and `mode` between boundaries have no effect until the next boundary.
- Reset asserted mid-period: the state after that edge equals the power-on state; out is 0 and no period_start is issued.
- Synchronous reset has priority over all other inputs.

## Test plan
- **Edge mode:** prescale=0, period=9, write ch0=3, then en=1 → out[0] high for 3 of every 10 clocks; period_start every 10 clocks; all other channels 0.
- **Center mode:** period=4, ch1=2 → cnt sequence 0,1,2,3,4,3,2,1; out[1] high for 3 of 8 clocks; period_start every 8 clocks.
- **Prescaler:** prescale=2, period=1, edge mode, ch2=1 → out[2] alternates 3 clocks high / 3 clocks low; period_start every 6 clocks.
- **Double buffering:**
  - Write ch0 from 3 to 7 at cnt=5 → current period keeps 3; next period shows 7.
  - Write coinciding with a boundary → takes effect one period later.
  - wr_ch=NCH → no channel changes.
- **Extremes:** period=9 with ch3=0 → out[3] constantly 0; ch3=10 or 255 → constant 1; period=0 → period_start on every tick.
- **Control:** rst pulse mid-period → out=0 and cnt restarts from 0 with duties cleared; en low for 5 clocks then high → out low, no period_start while disabled, and the first period after enable is full length.
